bram_word_serializer: RTL and testbench
=======================================

// Module: bram_word_serializer
// PURPOSE
//  Transmit side for the flat-vector register bank: captures one RAM_WIDTH*RAM_DEPTH word vector in one cycle,
//  then emits it one RAM_WIDTH entry per handshake with index and last flag. Sits between a bank's douta and a
//  word-serial consumer (DMA writeback, PE feed). Entry i occupies bits [i*RAM_WIDTH +: RAM_WIDTH].
// PARAMETERS
//  RAM_WIDTH  16  bits per entry
//  RAM_DEPTH  11  entries per vector (>=1); AW = clogb2(RAM_DEPTH-1), min 1
// PORTS
//  clka        in   1                    clock; all logic on posedge
//  rsta        in   1                    reset, synchronous, active-high
//  load_valid  in   1                    load_data valid
//  load_ready  out  1                    serializer can accept a vector
//  load_data   in   RAM_WIDTH*RAM_DEPTH  flat vector, entry 0 in LSBs
//  out_valid   out  1                    out_data/out_addr/out_last valid
//  out_ready   in   1                    consumer accepts current entry
//  out_data    out  RAM_WIDTH            current entry
//  out_addr    out  AW                   index of current entry
//  out_last    out  1                    current entry is final of vector
//  busy        out  1                    vector in flight (state SEND)
// BEHAVIOUR
//  - One clock clka; rsta is synchronous and active-high. rsta=1 at an edge -> state IDLE, idx=0, shadow=0.
//    Reset values: load_ready=1, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0.
//  - FSM: IDLE -> SEND on load accept; SEND -> SEND on entry accept with !out_last;
//    SEND -> IDLE on accept of last entry with no new load; SEND -> SEND (idx reset) on last accept + new load.
//  - load accept = load_valid & load_ready. Captures load_data into shadow reg, idx <= first index.
//  - load_ready = (state==IDLE) | (out_valid & out_ready & out_last): back-to-back vectors, no bubble.
//    Combinational path out_ready -> load_ready is intentional.
//  - Latency: load accepted at edge N -> out_valid=1 with entry 0 from cycle after edge N.
//  - out_valid = (state==SEND). out_data = shadow[idx*RAM_WIDTH +: RAM_WIDTH], out_addr = idx.
//  - Handshake: while out_valid & !out_ready, out_data/out_addr/out_last held stable; never drop valid.
//  - Entry accept (out_valid & out_ready): idx advances by one; after last entry idx wraps to first index.
//  - out_last = out_valid & (idx == last index). RAM_DEPTH=1: out_last high on the only entry.
//  - load_valid while SEND and not final accept: ignored (load_ready=0), load_data not sampled.
//  - rsta mid-vector: remaining entries discarded; out_valid low the cycle after the reset edge.
//  - Vector in shadow unaffected by load_data changes after capture.
// CONFIGURATION
//  SER_REVERSE_EN defined: first index = RAM_DEPTH-1, idx decrements, last index = 0 (entry D-1 sent first).
//  Undefined (default): first index = 0, idx increments, last index = RAM_DEPTH-1.
//  out_addr always reports the true entry index in both modes.
// STRUCTURE
//  Shared package bram_pkg: clogb2 function, state encoding (ST_IDLE=1'b0, ST_SEND=1'b1), default
//  RAM_WIDTH/RAM_DEPTH constants shared with the bank.
//  One sub-module: bram_word_select (combinational entry mux, flat vector + index -> RAM_WIDTH word).
// TESTING
//  1. Reset: rsta=1 two cycles -> load_ready=1, out_valid=0, out_data=0, out_addr=0, busy=0.
//  2. Default params, load entries i=16'h0100+i, out_ready=1 -> 11 beats 0x0100..0x010A, addr 0..10,
//     out_last only on addr 10, load_ready=1 the cycle after.
//  3. Backpressure: out_ready toggles 1,0,0,1 -> each entry held stable until accepted, no skip/duplicate.
//  4. Back-to-back: second vector (0xA000+i) on load_valid during last beat -> next cycle out 0xA000 addr 0.
//  5. Reset mid-vector: rsta=1 after beat 4 -> out_valid=0 next cycle; new load restarts at addr 0.
//  6. SER_REVERSE_EN: vector of test 2 -> beats 0x010A..0x0100, addr 10..0, out_last on addr 0.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the flat-vector register bank and its serializer:
// default geometry, serializer state encoding and address-width helpers.
package bram_pkg;

  localparam int unsigned RAM_WIDTH_DEF = 16;
  localparam int unsigned RAM_DEPTH_DEF = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Number of bits needed to represent value (0 -> 0).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v != 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

  // Index width for a bank of depth entries, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = (depth > 1) ? clogb2(depth - 1) : 0;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/bram_word_select.sv
// Combinational entry mux: picks entry sel out of a flat DEPTH x WIDTH vector
// (entry 0 in the LSBs). Out-of-range sel yields zero.
module bram_word_select
  import bram_pkg::*;
#(
  parameter int unsigned WIDTH = RAM_WIDTH_DEF,
  parameter int unsigned DEPTH = RAM_DEPTH_DEF,
  parameter int unsigned AW    = addr_width(RAM_DEPTH_DEF)
) (
  input  logic [WIDTH*DEPTH-1:0] vec,
  input  logic [AW-1:0]          sel,
  output logic [WIDTH-1:0]       word
);

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel == AW'(i)) begin
        word = vec[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/bram_word_serializer.sv
// Captures a whole RAM_WIDTH*RAM_DEPTH vector and streams it out one entry per
// valid/ready handshake with index and last flag. Define SER_REVERSE_EN to send
// entry RAM_DEPTH-1 first and count down to entry 0.
module bram_word_serializer
  import bram_pkg::*;
#(
  parameter  int unsigned RAM_WIDTH = RAM_WIDTH_DEF,
  parameter  int unsigned RAM_DEPTH = RAM_DEPTH_DEF,
  localparam int unsigned AW        = addr_width(RAM_DEPTH)
) (
  input  logic                           clka,
  input  logic                           rsta,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [RAM_WIDTH*RAM_DEPTH-1:0] load_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RAM_WIDTH-1:0]           out_data,
  output logic [AW-1:0]                  out_addr,
  output logic                           out_last,
  output logic                           busy
);

`ifdef SER_REVERSE_EN
  localparam logic [AW-1:0] FIRST_IDX = AW'(RAM_DEPTH - 1);
  localparam logic [AW-1:0] LAST_IDX  = '0;
`else
  localparam logic [AW-1:0] FIRST_IDX = '0;
  localparam logic [AW-1:0] LAST_IDX  = AW'(RAM_DEPTH - 1);
`endif

  ser_state_t                     state;
  logic [AW-1:0]                  idx;
  logic [AW-1:0]                  idx_next;
  logic [RAM_WIDTH*RAM_DEPTH-1:0] shadow;
  logic                           load_accept;
  logic                           entry_accept;

  assign out_valid    = (state == ST_SEND);
  assign busy         = (state == ST_SEND);
  assign out_addr     = idx;
  assign out_last     = out_valid & (idx == LAST_IDX);
  assign entry_accept = out_valid & out_ready;

  // Ready again during the final accepted beat so vectors can run back-to-back.
  assign load_ready   = (state == ST_IDLE) | (entry_accept & out_last);
  assign load_accept  = load_valid & load_ready;

`ifdef SER_REVERSE_EN
  assign idx_next = idx - AW'(1);
`else
  assign idx_next = idx + AW'(1);
`endif

  always_ff @(posedge clka) begin
    if (rsta) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shadow <= '0;
    end else if (load_accept) begin
      state  <= ST_SEND;
      idx    <= FIRST_IDX;
      shadow <= load_data;
    end else if (entry_accept) begin
      if (out_last) begin
        state <= ST_IDLE;
        idx   <= FIRST_IDX;
      end else begin
        idx <= idx_next;
      end
    end
  end

  bram_word_select #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (RAM_DEPTH),
    .AW    (AW)
  ) u_select (
    .vec  (shadow),
    .sel  (idx),
    .word (out_data)
  );

endmodule

// File: tb/tb_bram_word_serializer.sv
// Directed bench for bram_word_serializer (11 x 16-bit vectors); honours
// SER_REVERSE_EN when the design is built with it.
module tb_bram_word_serializer;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 11;
  localparam int unsigned AW = 4;

  logic           clka = 1'b0;
  logic           rsta;
  logic           load_valid;
  logic           load_ready;
  logic [W*D-1:0] load_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [AW-1:0]  out_addr;
  logic           out_last;
  logic           busy;

  int vectors    = 0;
  int miscompares = 0;

  bram_word_serializer #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (D)
  ) dut (
    .clka       (clka),
    .rsta       (rsta),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clka = ~clka;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*D-1:0] mkvec(input logic [15:0] base);
    logic [W*D-1:0] v;
    v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = base + 16'(i);
    return v;
  endfunction

  // Entry index sent on the k-th beat of a vector.
  function automatic int ent(input int k);
`ifdef SER_REVERSE_EN
    return D - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check_beat(input logic [15:0] base, input int k);
    chk("valid", 32'(out_valid), 32'd1);
    chk("data",  32'(out_data),  32'(base + 16'(ent(k))));
    chk("addr",  32'(out_addr),  32'(ent(k)));
    chk("last",  32'(out_last),  32'(k == D - 1));
  endtask

  task automatic drain(input logic [15:0] base, input int from, input int to);
    for (int k = from; k < to; k++) begin
      out_ready = 1'b1;
      #1;
      check_beat(base, k);
      chk("ld_rdy_beat", 32'(load_ready), 32'(k == D - 1));
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_busy"},   32'(busy),       32'd0);
    chk({tag, "_ld_rdy"}, 32'(load_ready), 32'd1);
    chk({tag, "_last"},   32'(out_last),   32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int k;

    rsta = 1'b1; load_valid = 1'b0; load_data = '0; out_ready = 1'b0;

    // 1. reset
    tick(); tick();
    check_idle("rst");
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    rsta = 1'b0;
    tick();

    // 2. full vector with out_ready held high; shadow must ignore later load_data
    load_data = mkvec(16'h0100); load_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("t2_ld_rdy", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0; load_data = mkvec(16'h7700);
    drain(16'h0100, 0, D);
    check_idle("t2_end");

    // 3. backpressure pattern 1,0,0,1
    load_data = mkvec(16'h0200); load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    pat = 4'b1001;
    k = 0;
    for (int c = 0; c < 60 && k < D; c++) begin
      out_ready = pat[c % 4];
      #1;
      check_beat(16'h0200, k);
      if (!out_ready) chk("t3_ld_rdy_stall", 32'(load_ready), 32'd0);
      if (out_ready) k++;
      tick();
    end
    chk("t3_beats", 32'(k), 32'(D));
    check_idle("t3_end");

    // 4. back-to-back vectors, second load during last beat
    out_ready = 1'b1;
    load_data = mkvec(16'h0300); load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    drain(16'h0300, 0, D - 1);
    load_data = mkvec(16'hA000); load_valid = 1'b1;
    #1;
    check_beat(16'h0300, D - 1);
    chk("t4_ld_rdy_last", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);
    drain(16'hA000, 0, D);
    check_idle("t4_end");

    // 5. load ignored mid-vector, then reset after beat 4
    load_data = mkvec(16'h0500); load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    drain(16'h0500, 0, 1);
    load_data = mkvec(16'h0F00); load_valid = 1'b1;
    #1;
    chk("t5_ld_rdy_busy", 32'(load_ready), 32'd0);
    drain(16'h0500, 1, 4);
    load_valid = 1'b0;
    rsta = 1'b1; out_ready = 1'b0;
    tick();
    rsta = 1'b0;
    check_idle("t5_rst");
    chk("t5_rst_addr", 32'(out_addr), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    load_data = mkvec(16'h0600); load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    drain(16'h0600, 0, D);
    check_idle("t5_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
